// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and control unit for the IF -> ID -> EX -> WB pipeline.
//   It keeps a per-register write-pending scoreboard. It stalls IF/ID and
//   inserts ID/EX bubbles on RAW and WAW hazards. It also freezes fetch
//   while a branch or jump is in flight, then flushes IF/ID on a redirect.
//
//   Build option:
//     HAZARD_BYPASS_EN  Define this when the register file writes through.
//                       A WB write then releases a waiting consumer in the
//                       same cycle. Leave it undefined and the consumer
//                       waits one extra cycle after the WB write.
//
//   Handshake: this block has no valid/ready pairs. id_valid and wb_valid
//   are qualifiers sampled every cycle. An ID instruction issues when
//   id_valid=1 in a cycle where stall_if=0 and bubble_id=0 in IDLE.
//   Otherwise the CPU must hold that instruction unchanged in IF/ID.
//
//   fsm_state is a debug view of the branch FSM
//   (0=IDLE, 1=BR_WAIT, 2=REDIR).

module pipeline_hazard_ctrl #(
    parameter int NUM_REGS = 64,
    parameter int REG_AW   = 6,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_regwrt,
    input  logic                id_branch,
    input  logic                wb_valid,
    input  logic                wb_regwrt,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                wb_redirect,
    output logic                stall_if,
    output logic                bubble_id,
    output logic                flush_ifid,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_REDIR   = 2'd2
    } state_e;

    state_e              state_q;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] eff;
    logic                haz;
    logic                issue;

    // One-hot decode of a register index. An index that has no matching
    // scoreboard bit decodes to zero, so it sets, clears and hazards nothing.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == REG_AW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Scoreboard clear from WB. This also builds the view used for hazard
    // checks: in the bypass build a same-cycle WB write no longer blocks.
    always_comb begin
        clr_vec = '0;
        if (wb_valid && wb_regwrt) begin
            clr_vec = reg_onehot(wb_rd);
        end
`ifdef HAZARD_BYPASS_EN
        eff = pending_q & ~clr_vec;
`else
        eff = pending_q;
`endif
    end

    // Hazard detection and issue decision for the instruction in ID.
    always_comb begin
        haz = id_valid & (
                  (id_rs_used & |(eff & reg_onehot(id_rs))) |
                  (id_rt_used & |(eff & reg_onehot(id_rt))) |
                  (id_regwrt  & |(eff & reg_onehot(id_rd))));
        issue = id_valid & ~haz & (state_q == ST_IDLE);
        set_vec = '0;
        if (issue && id_regwrt) begin
            set_vec = reg_onehot(id_rd);
        end
        // The set is OR-ed in last. When the same register is set and
        // cleared on one edge, it stays pending.
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    // Pipeline control outputs. They are driven directly from the FSM
    // state and the hazard term, so they add no latency.
    always_comb begin
        stall_if   = 1'b0;
        bubble_id  = 1'b0;
        flush_ifid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_if  = haz;
                bubble_id = haz;
            end
            ST_BR_WAIT: begin
                stall_if  = 1'b1;
                bubble_id = 1'b1;
            end
            ST_REDIR: begin
                flush_ifid = 1'b1;
                bubble_id  = 1'b1;
            end
            default: begin
                stall_if   = 1'b0;
                bubble_id  = 1'b0;
                flush_ifid = 1'b0;
            end
        endcase
    end

    // Stall-cycle counter. It stops at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Branch FSM. Fetch is frozen from branch issue until the branch
    // resolves in WB. A taken branch then spends one cycle flushing IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue && id_branch) begin
                        state_q <= ST_BR_WAIT;
                    end
                end
                ST_BR_WAIT: begin
                    if (wb_valid) begin
                        state_q <= wb_redirect ? ST_REDIR : ST_IDLE;
                    end
                end
                ST_REDIR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Scoreboard and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pending   = pending_q;
    assign stall_cnt = stall_cnt_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. The DUT is built with CNT_W=4, so the
// stall counter saturates early. Expected control outputs for each cycle
// go into exp_q when the stimulus is driven. They are popped and compared
// at the following falling edge.

module tb_pipeline_hazard_ctrl;

  localparam int NR = 64;
  localparam int AW = 6;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [AW-1:0] id_rd;
  logic          id_regwrt;
  logic          id_branch;
  logic          wb_valid;
  logic          wb_regwrt;
  logic [AW-1:0] wb_rd;
  logic          wb_redirect;
  logic          stall_if;
  logic          bubble_id;
  logic          flush_ifid;
  logic [NR-1:0] pending;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    fsm_state;

  logic [2:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  pipeline_hazard_ctrl #(.NUM_REGS(NR), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_regwrt(id_regwrt), .id_branch(id_branch),
    .wb_valid(wb_valid), .wb_regwrt(wb_regwrt), .wb_rd(wb_rd),
    .wb_redirect(wb_redirect),
    .stall_if(stall_if), .bubble_id(bubble_id), .flush_ifid(flush_ifid),
    .pending(pending), .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd();
    return AW'($urandom_range(0, NR - 1));
  endfunction

  // driver tasks
  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic rsu,
                        input logic [AW-1:0] rt, input logic rtu,
                        input logic [AW-1:0] rd, input logic rw, input logic br);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_regwrt = rw; id_branch = br;
  endtask

  task automatic id_off();
    set_id(1'b0, rnd(), 1'b0, rnd(), 1'b0, rnd(), 1'b0, 1'b0);
  endtask

  task automatic set_wb(input logic v, input logic rw, input logic [AW-1:0] rd, input logic red);
    wb_valid = v; wb_regwrt = rw; wb_rd = rd; wb_redirect = red;
  endtask

  task automatic wb_off();
    set_wb(1'b0, 1'b0, rnd(), 1'b0);
  endtask

  // Called at posedge+1 with inputs driven. The task pushes the expected
  // {stall_if,bubble_id,flush_ifid}, compares at the falling edge, and
  // returns at the next posedge+1.
  task automatic tick(input string tag, input logic [2:0] exp);
    logic [2:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, 64'({stall_if, bubble_id, flush_ifid}), 64'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic check_pend(input string tag, input logic [63:0] exp);
    check(tag, 64'(pending), exp);
  endtask

  initial begin
    rst_n = 1'b0;
    id_off();
    wb_off();
    #3;
    // reset state
    check("rst_ctl", 64'({stall_if, bubble_id, flush_ifid}), 64'(0));
    check("rst_pend", 64'(pending), 64'(0));
    check("rst_cnt", 64'(stall_cnt), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAW on r3
    set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0);
    tick("raw_issue", 3'b000);
    check_pend("raw_set", 64'h8);
    set_id(1'b1, 6'd3, 1'b1, rnd(), 1'b0, 6'd4, 1'b1, 1'b0);
    tick("raw_stall1", 3'b110);
    tick("raw_stall2", 3'b110);
    set_wb(1'b1, 1'b1, 6'd3, 1'b0);
`ifdef HAZARD_BYPASS_EN
    tick("raw_wb_release", 3'b000);
    wb_off();
    id_off();
`else
    tick("raw_wb_stall", 3'b110);
    wb_off();
    tick("raw_release", 3'b000);
    id_off();
`endif
    check_pend("raw_clr", 64'h10);
`ifdef HAZARD_BYPASS_EN
    check("raw_cnt", 64'(stall_cnt), 64'(2));
`else
    check("raw_cnt", 64'(stall_cnt), 64'(3));
`endif
    set_wb(1'b1, 1'b1, 6'd4, 1'b0);
    tick("clr4", 3'b000);
    wb_off();
    check_pend("clr4_pend", 64'h0);

    // WAW with a simultaneous WB clear on r7
    set_id(1'b1, rnd(), 1'b0, rnd(), 1'b0, 6'd7, 1'b1, 1'b0);
    tick("waw_first", 3'b000);
    check_pend("waw_set", 64'h80);
    set_id(1'b1, rnd(), 1'b0, rnd(), 1'b0, 6'd7, 1'b1, 1'b0);
    set_wb(1'b1, 1'b1, 6'd7, 1'b0);
`ifdef HAZARD_BYPASS_EN
    tick("waw_same_edge", 3'b000);
    wb_off();
    id_off();
`else
    tick("waw_stall", 3'b110);
    wb_off();
    tick("waw_issue", 3'b000);
    id_off();
`endif
    check_pend("waw_keep", 64'h80);
    set_wb(1'b1, 1'b1, 6'd7, 1'b0);
    tick("clr7", 3'b000);
    wb_off();
    check_pend("clr7_pend", 64'h0);

    // taken branch
    set_id(1'b1, rnd(), 1'b0, rnd(), 1'b0, rnd(), 1'b0, 1'b1);
    tick("tk_issue", 3'b000);
    set_id(1'b1, 6'd0, 1'b1, rnd(), 1'b0, rnd(), 1'b0, 1'b0);
    tick("tk_wait1", 3'b110);
    set_wb(1'b1, 1'b0, rnd(), 1'b1);
    tick("tk_wait2", 3'b110);
    wb_off();
    tick("tk_flush", 3'b011);
    check("tk_state", 64'(fsm_state), 64'(0));
    id_off();
    tick("tk_after", 3'b000);

    // not-taken branch; the held instruction writes r5
    set_id(1'b1, rnd(), 1'b0, rnd(), 1'b0, rnd(), 1'b0, 1'b1);
    tick("nt_issue", 3'b000);
    set_id(1'b1, 6'd0, 1'b1, rnd(), 1'b0, 6'd5, 1'b1, 1'b0);
    tick("nt_wait1", 3'b110);
    set_wb(1'b1, 1'b0, rnd(), 1'b0);
    tick("nt_wait2", 3'b110);
    wb_off();
    tick("nt_proceed", 3'b000);
    id_off();
    check_pend("nt_pend", 64'h20);
    check("nt_state", 64'(fsm_state), 64'(0));
    set_wb(1'b1, 1'b1, 6'd5, 1'b0);
    tick("clr5", 3'b000);
    wb_off();
`ifdef HAZARD_BYPASS_EN
    check("br_cnt", 64'(stall_cnt), 64'(6));
`else
    check("br_cnt", 64'(stall_cnt), 64'(8));
`endif

    // asynchronous reset in the middle of BR_WAIT with pending=0x5
    set_id(1'b1, rnd(), 1'b0, rnd(), 1'b0, 6'd0, 1'b1, 1'b0);
    tick("ar_r0", 3'b000);
    set_id(1'b1, rnd(), 1'b0, rnd(), 1'b0, 6'd2, 1'b1, 1'b1);
    tick("ar_br", 3'b000);
    id_off();
    tick("ar_wait", 3'b110);
    check_pend("ar_pend_pre", 64'h5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ctl", 64'({stall_if, bubble_id, flush_ifid}), 64'(0));
    check("ar_pend", 64'(pending), 64'(0));
    check("ar_cnt", 64'(stall_cnt), 64'(0));
    check("ar_state", 64'(fsm_state), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // saturation of the stall counter
    set_id(1'b1, rnd(), 1'b0, rnd(), 1'b0, 6'd9, 1'b1, 1'b0);
    tick("sat_issue", 3'b000);
    set_id(1'b1, 6'd9, 1'b1, rnd(), 1'b0, rnd(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick("sat_stall", 3'b110);
    check("sat_cnt", 64'(stall_cnt), 64'(15));
    for (int i = 0; i < 2; i++) tick("sat_hold_stall", 3'b110);
    check("sat_hold", 64'(stall_cnt), 64'(15));
    id_off();
    set_wb(1'b1, 1'b1, 6'd9, 1'b0);
    tick("clr9", 3'b000);
    wb_off();
    check_pend("end_pend", 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
